rc2014_mem_arbiter: RTL
=======================

# rc2014_mem_arbiter

Shares one single-port synchronous block RAM between the RC2014 Z80 bus and an internal requester, such as a video fetch or loader. The Z80 bus has fixed priority; the internal port uses a req/ack handshake and is served only when no Z80 access is pending. The block sits between the bus pins (address, data, active-low strobes, data-buffer enable) and the RAM. It replaces direct ROM-to-bus wiring with a decoded, sequenced window that also supports writes.

## Interface
- `ADDR_W`, 13: RAM address width; window size is 2**ADDR_W bytes.
- `BASE`, 16'h0000: Z80 base address of the window; must be aligned to 2**ADDR_W.
- `CLK` in 1: system clock; must be ≥ 8× the Z80 clock.
- `RST` in 1: synchronous reset, active-high.
- `A` in 16: Z80 address bus.
- `D_IN` in 8: Z80 data bus, input side.
- `D_OUT` out 8: data driven onto the Z80 bus.
- `DATA_OE` out 1: data buffer enable; 0 means the FPGA drives the bus.
- `RD`, `WR`, `MRQ` in 1 each: Z80 strobes, active-low, asynchronous to `CLK`.
- `int_req` in 1: internal access request.
- `int_we` in 1: internal write (1) or read (0).
- `int_addr` in ADDR_W: internal access address.
- `int_wdata` in 8: internal write data.
- `int_ack` out 1: one-cycle pulse; the internal access is issued this cycle.
- `int_rvalid` out 1: one-cycle pulse; `int_rdata` is valid.
- `int_rdata` out 8: internal read data.
- `mem_addr` out ADDR_W: RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out 8: RAM write data.
- `mem_rdata` in 8: RAM read data, valid 1 cycle after the address.

## Operation
**Strobe synchronisation**
- `RD`, `WR`, `MRQ` pass through 2-flop synchronisers; the flops reset to 1.
- `rd_s = !RD_sync & !MRQ_sync`; `wr_s = !WR_sync & !MRQ_sync`.
- `hit = (A >= BASE) && (A < BASE + 2**ADDR_W)`. `A` and `D_IN` are sampled in the cycle a strobe is detected.
- IORQ, refresh (MRQ with no RD/WR) and non-hit cycles cause no action.

**State machine**
- IDLE:
  - `rd_s & hit` → BUS_RD, with `mem_addr = A[ADDR_W-1:0]`.
  - `wr_s & hit` → BUS_WR.
  - Otherwise, `int_req` → INT, with `int_ack = 1` and the RAM driven from the internal port.
  - Bus requests have priority over `int_req` in the same cycle.
- BUS_RD: wait one cycle for RAM latency → BUS_CAP.
- BUS_CAP:
  - `D_OUT <= mem_rdata`, set `drive_en`.
  - If `rd_s` has already dropped, clear `drive_en` and go to IDLE.
  - Otherwise → HOLD.
- BUS_WR: `mem_we = 1` for exactly one cycle, with `mem_wdata = D_IN` sampled at detection → HOLD.
- HOLD: stay until `rd_s` and `wr_s` are both 0, then clear `drive_en` → IDLE. This guarantees one RAM access per Z80 cycle.
- INT: one cycle.
  - Read: `int_rdata <= mem_rdata` and `int_rvalid = 1` in the following cycle, which may overlap IDLE.
  - Then → IDLE.

**Bus drive and handshake**
- `DATA_OE = !(drive_en & !RD & !MRQ)`, using the raw pins. The bus is released combinationally the moment the Z80 deasserts.
- Requester rule: hold `int_req`, `int_we`, `int_addr` and `int_wdata` stable until `int_ack`. Drop `int_req` in the cycle after `int_ack`, or keep it high to request a back-to-back access.
- `int_ack` never coincides with a Z80 RAM access.

## Timing
**Reset values**
- `DATA_OE = 1`, `D_OUT = 8'h00`, `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- `int_ack = 0`, `int_rvalid = 0`, `int_rdata = 8'h00`.
- State is IDLE and `drive_en = 0`.
- A reset in the middle of a cycle aborts it: no write and no drive. The synchronisers re-arm, so a strobe still asserted after reset is detected as a new access.

**Latency**
- Bus read: strobe pin fall → `DATA_OE = 0` with valid `D_OUT` in ≤ 5 `CLK` (2 sync + IDLE + BUS_RD + BUS_CAP).
- Worst case adds 1 `CLK` if an INT cycle is in progress when the strobe is detected.
- Bus write: `mem_we` is asserted 3 `CLK` after the WR pin falls (+1 if INT is in progress).
- Internal read: `int_ack` in cycle N → `int_rvalid` in N+1.
- Internal port throughput: 1 access per 2 `CLK` maximum.

**Boundary conditions**
- Address `BASE + 2**ADDR_W - 1` hits; `BASE + 2**ADDR_W` does not; `BASE - 1` does not.
- A strobe shorter than the sync plus one cycle may be missed; this is legal only for non-hit cycles.
- RD and WR both asserted: treated as a read.
- `int_req` held throughout a long Z80 cycle is starved until HOLD exits. The requester must tolerate this.

## Test plan
- **Reset:** assert `RST` with RD and MRQ low and `A = 16'h0010` → `DATA_OE = 1`, no `mem_we`, `int_ack = 0`. Release `RST` → the read is served after a fresh sync.
- **Bus read:** RAM[0x0123] = 8'hA5; drive `A = 16'h0123`, MRQ and RD low → within 5 `CLK`, `DATA_OE = 0` and `D_OUT = 8'hA5`. Raise RD → `DATA_OE = 1` combinationally.
- **Bus write:** `A = 16'h1FFF`, `D_IN = 8'h3C`, MRQ and WR low → exactly one `mem_we` pulse with `mem_addr = 13'h1FFF`, `mem_wdata = 8'h3C`. `A = 16'h2000` → no `mem_we`.
- **Collision:** `int_req` read of 0x0040 in the same cycle a bus read is detected → the bus is served first. `int_ack` follows after HOLD exits, then `int_rvalid` one cycle later with RAM[0x0040].
- **Ignored cycles:** refresh cycle (MRQ low, no RD/WR) and an IORQ read at 0x0001 → no state change, `DATA_OE` stays 1, and a pending `int_req` is acked in ≤ 2 `CLK`.
- **Back-to-back internal:** 4 internal writes with `int_req` held high → 4 `int_ack` pulses spaced 2 `CLK` apart, and RAM contents verified afterwards.

Source files
------------

// File: rtl/rc2014_mem_arbiter_if.sv
// rc2014_mem_arbiter_if: Z80 bus pins, internal req/ack port and RAM port of the arbiter
interface rc2014_mem_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic [15:0]       a;
  logic [7:0]        d_in;
  logic [7:0]        d_out;
  logic              data_oe;
  logic              rd_n;
  logic              wr_n;
  logic              mrq_n;
  logic              int_req;
  logic              int_we;
  logic [ADDR_W-1:0] int_addr;
  logic [7:0]        int_wdata;
  logic              int_ack;
  logic              int_rvalid;
  logic [7:0]        int_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  modport slave (
    input  a, d_in, rd_n, wr_n, mrq_n, int_req, int_we, int_addr, int_wdata, mem_rdata,
    output d_out, data_oe, int_ack, int_rvalid, int_rdata, mem_addr, mem_we, mem_wdata
  );
  modport master (
    output a, d_in, rd_n, wr_n, mrq_n, int_req, int_we, int_addr, int_wdata, mem_rdata,
    input  d_out, data_oe, int_ack, int_rvalid, int_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/rc2014_mem_arbiter.sv
// rc2014_mem_arbiter: shares one sync RAM between the RC2014 Z80 bus (fixed priority) and an internal req/ack port
module rc2014_mem_arbiter #(
  parameter int          ADDR_W = 13,
  parameter logic [15:0] BASE   = 16'h0000
) (
  input logic                 clk_i,
  input logic                 rst_i,
  rc2014_mem_arbiter_if.slave bus_if
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] BUS_RD  = 3'd1;
  localparam logic [2:0] BUS_CAP = 3'd2;
  localparam logic [2:0] BUS_WR  = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;
  localparam logic [2:0] INT     = 3'd5;
  localparam logic [16:0] LO = {1'b0, BASE};
  localparam logic [16:0] HI = LO + (17'd1 << ADDR_W);
  logic [1:0]        rd_sync_q, wr_sync_q, mrq_sync_q;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, drive_q, drive_d, ack_q, ack_d, rvalid_q, rvalid_d;
  logic [7:0]        wdata_q, wdata_d, dout_q, dout_d, rdata_q, rdata_d;
  logic              rd_s, wr_s, hit;
  assign rd_s = !rd_sync_q[1] && !mrq_sync_q[1];
  assign wr_s = !wr_sync_q[1] && !mrq_sync_q[1];
  assign hit  = ({1'b0, bus_if.a} >= LO) && ({1'b0, bus_if.a} < HI);
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    drive_d  = drive_q;
    dout_d   = dout_q;
    ack_d    = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = rvalid_q ? bus_if.mem_rdata : rdata_q;
    case (state_q)
      IDLE:
        if ((rd_s || wr_s) && hit) begin
          state_d = rd_s ? BUS_RD : BUS_WR;
          addr_d  = bus_if.a[ADDR_W-1:0];
          we_d    = !rd_s;
          wdata_d = bus_if.d_in;
        end else if (bus_if.int_req) begin
          state_d = INT;
          addr_d  = bus_if.int_addr;
          we_d    = bus_if.int_we;
          wdata_d = bus_if.int_wdata;
          ack_d   = 1'b1;
        end
      BUS_RD:  state_d = BUS_CAP;
      BUS_CAP: begin
        dout_d  = bus_if.mem_rdata;
        drive_d = rd_s;
        state_d = rd_s ? HOLD : IDLE;
      end
      BUS_WR:  state_d = HOLD;
      // one RAM access per Z80 cycle: wait for both strobes to drop
      HOLD:
        if (!rd_s && !wr_s) begin
          drive_d = 1'b0;
          state_d = IDLE;
        end
      INT: begin
        rvalid_d = !we_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_sync_q  <= 2'b11;
      wr_sync_q  <= 2'b11;
      mrq_sync_q <= 2'b11;
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      drive_q    <= 1'b0;
      dout_q     <= '0;
      ack_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rd_sync_q  <= {rd_sync_q[0], bus_if.rd_n};
      wr_sync_q  <= {wr_sync_q[0], bus_if.wr_n};
      mrq_sync_q <= {mrq_sync_q[0], bus_if.mrq_n};
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      drive_q    <= drive_d;
      dout_q     <= dout_d;
      ack_q      <= ack_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end
  // raw pins release the bus the instant the Z80 deasserts
  assign bus_if.data_oe    = !(drive_q && !bus_if.rd_n && !bus_if.mrq_n);
  assign bus_if.d_out      = dout_q;
  assign bus_if.int_ack    = ack_q;
  assign bus_if.int_rvalid = rvalid_q;
  assign bus_if.int_rdata  = rdata_d;
  assign bus_if.mem_addr   = addr_q;
  assign bus_if.mem_we     = we_q;
  assign bus_if.mem_wdata  = wdata_q;
endmodule
